// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

    // A redirect target is usable only when it lands on a word boundary.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (en && (count_reg != {WIDTH{1'b1}})) begin
            count_next = count_reg + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, loads IF/ID from a same-cycle
// instruction memory and honours halt, redirect and stall commands.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_WORDS  = 256,
    parameter int          STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   halt_req,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic [31:0]            imem_addr,
    input  logic [31:0]            imem_data,
    output logic [31:0]            if_id_instr,
    output logic [31:0]            if_id_pc,
    output logic                   if_id_valid,
    output logic                   running,
    output logic                   halted,
    output logic                   fault,
    output logic [31:0]            fetch_count,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [31:0] FETCH_LIMIT = 32'(IMEM_WORDS * 4);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  instr_reg, instr_next;
    logic [31:0]  id_pc_reg, id_pc_next;
    logic         valid_reg, valid_next;
    logic         fault_reg, fault_next;
    logic [31:0]  fetch_count_reg, fetch_count_next;
    logic         stall_en;

    // Priority inside RUN: halt, bad redirect, redirect, stall, limit, fetch.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        instr_next       = instr_reg;
        id_pc_next       = id_pc_reg;
        valid_next       = valid_reg;
        fault_next       = fault_reg;
        fetch_count_next = fetch_count_reg;
        stall_en         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (halt_req) begin
                    state_next = HALT;
                end else if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_next = HALT;
                    valid_next = 1'b0;
                end else if (redirect && is_misaligned(redirect_pc)) begin
                    fault_next = 1'b1;
                    state_next = HALT;
                    valid_next = 1'b0;
                end else if (redirect) begin
                    // Squash wins over stall so the bubble is never frozen in place.
                    pc_next    = redirect_pc;
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                end else if (stall) begin
                    stall_en = 1'b1;
                end else if (pc_reg >= FETCH_LIMIT) begin
                    state_next = HALT;
                    valid_next = 1'b0;
                end else begin
                    instr_next       = imem_data;
                    id_pc_next       = pc_reg;
                    valid_next       = 1'b1;
                    pc_next          = pc_reg + 32'd4;
                    fetch_count_next = fetch_count_reg + 32'd1;
                end
            end
            HALT: begin
                valid_next = 1'b0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC;
            instr_reg       <= NOP_INSTR;
            id_pc_reg       <= 32'h0;
            valid_reg       <= 1'b0;
            fault_reg       <= 1'b0;
            fetch_count_reg <= 32'h0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            instr_reg       <= instr_next;
            id_pc_reg       <= id_pc_next;
            valid_reg       <= valid_next;
            fault_reg       <= fault_next;
            fetch_count_reg <= fetch_count_next;
        end
    end

    sat_counter #(
        .WIDTH(STALL_CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clr_n(rst_n),
        .en   (stall_en),
        .count(stall_count)
    );

    assign imem_addr   = pc_reg;
    assign if_id_instr = instr_reg;
    assign if_id_pc    = id_pc_reg;
    assign if_id_valid = valid_reg;
    assign running     = (state_reg == RUN);
    assign halted      = (state_reg == HALT);
    assign fault       = fault_reg;
    assign fetch_count = fetch_count_reg;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the hazard-stall pipeline. It owns the PC and drives the address of the combinational instruction memory, which returns data in the same cycle. It loads the IF/ID pipeline register and obeys stall and redirect commands from the hazard/branch logic. It also provides run/halt control and fetch/stall statistics for the bench.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset; must be word aligned.
IMEM_WORDS, 256, instruction memory depth in words; the fetch limit is IMEM_WORDS*4.
STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  synchronous, active-low reset.
start  in  1  leave IDLE and begin fetching.
halt_req  in  1  request to stop fetching.
stall  in  1  hazard unit freezes the PC and IF/ID.
redirect  in  1  branch/jump taken; squash IF/ID.
redirect_pc  in  32  target of the redirect.
imem_addr  out  32  byte address to instruction memory; always equals pc.
imem_data  in  32  instruction word at imem_addr, same cycle.
if_id_instr  out  32  IF/ID instruction.
if_id_pc  out  32  IF/ID instruction's PC.
if_id_valid  out  1  IF/ID holds a real instruction.
running  out  1  FSM is in RUN.
halted  out  1  FSM is in HALT.
fault  out  1  misaligned redirect was detected; sticky.
fetch_count  out  32  number of instructions loaded into IF/ID.
stall_count  out  STALL_CNT_W  stalled RUN cycles, saturating.

Behaviour:
- Reset (rst_n=0 at an edge) applies in any state, including mid-stall or mid-redirect:
  - pc=RESET_PC, state=IDLE.
  - if_id_instr=32'h0, if_id_pc=0, if_id_valid=0.
  - fault=0, fetch_count=0, stall_count=0.
  - running=0, halted=0.
- FSM states: IDLE, RUN, HALT. Outputs running/halted decode the state combinationally.
- IDLE:
  - PC and IF/ID hold.
  - halt_req=1 -> HALT. Otherwise start=1 -> RUN.
  - stall and redirect are ignored.
- RUN, priority per cycle (highest first):
  1. halt_req: next state HALT; if_id_valid<=0; pc holds.
  2. redirect with redirect_pc[1:0]!=0: fault<=1; next state HALT; if_id_valid<=0.
  3. redirect (aligned): pc<=redirect_pc; if_id_instr<=0 (NOP); if_id_valid<=0. The squash happens even if stall=1, since redirect wins over stall.
  4. stall: pc and all IF/ID registers hold; stall_count increments, saturating at all-ones.
  5. pc >= IMEM_WORDS*4: next state HALT without fetching; if_id_valid<=0; fault stays 0.
  6. normal fetch: if_id_instr<=imem_data; if_id_pc<=pc; if_id_valid<=1; pc<=pc+4 (32-bit wrap); fetch_count<=fetch_count+1 (32-bit wrap).
- Latency:
  - Instruction at pc appears in IF/ID one cycle after the fetch edge.
  - First valid IF/ID occurs 2 edges after start is sampled: one edge IDLE->RUN, one edge fetch.
  - Redirect produces exactly one bubble cycle; the target instruction is valid in IF/ID 2 edges after redirect is sampled.
- HALT: terminal until reset. pc, fetch_count and stall_count freeze; if_id_valid=0; all inputs ignored.
- imem_addr is combinational from the pc register and never from an input, so there is no input-to-output path.

Decomposition:
- fetch_pkg holds:
  - state enum {IDLE, RUN, HALT} as a 2-bit encoding;
  - NOP_INSTR=32'h0;
  - ALIGN_MASK=2'b11.
- One natural sub-module: sat_counter (width parameter, enable, synchronous active-low clear), used for stall_count.
- The FSM, PC and IF/ID registers stay in fetch_ctrl.

Test Plan:
- Reset, start, no stalls, imem preloaded with 0x2008000A, 0x20090008, 0x01095025 -> IF/ID shows 0x2008000A/pc 0, then 0x20090008/pc 4, then 0x01095025/pc 8 on consecutive cycles; fetch_count=3.
- Stall held 2 cycles while IF/ID has pc 8 -> IF/ID and pc frozen; stall_count=2; fetch resumes at pc 12 with no lost or duplicated instruction.
- redirect=1 with redirect_pc=0x10 together with stall=1 -> next cycle if_id_valid=0 and pc=0x10; following cycle IF/ID holds mem[4] with pc 0x10.
- redirect_pc=0x13 -> fault=1, halted=1, pc unchanged, if_id_valid=0.
- Run with IMEM_WORDS=4 -> after pc 12 is fetched, HALT entered with fault=0 and fetch_count=4.
- Assert rst_n=0 while in HALT, and separately mid-stall -> all outputs return to reset values on the next edge; a subsequent start restarts fetch from RESET_PC.
